// File: rtl/sync_fifo.sv
// Single-clock valid/ready FIFO with exact fill count, almost flags, flush and optional fall-through.
// Define SYNC_FIFO_WATERMARK_EN to add the max_count_o high-water-mark output.
module sync_fifo #(
   parameter int ELEM_WIDTH   = 8,
   parameter int DEPTH        = 4,
   parameter bit FALL_THROUGH = 1'b0,
   parameter int AF_LEVEL     = DEPTH - 1,
   parameter int AE_LEVEL     = 1
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         flush_i,
   input  logic [ELEM_WIDTH-1:0]        elem_in_i,
   input  logic                         elem_in_valid_i,
   output logic                         elem_in_ready_o,
   output logic [ELEM_WIDTH-1:0]        elem_out_o,
   output logic                         elem_out_valid_o,
   input  logic                         elem_out_ready_i,
`ifdef SYNC_FIFO_WATERMARK_EN
   output logic [$clog2(DEPTH+1)-1:0]   max_count_o,
`endif
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         almost_full_o,
   output logic                         almost_empty_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ELEM_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;
   logic                  empty;
   logic                  full;
   logic                  bypass_show;
   logic                  push_req;
   logic                  pop_req;
   logic                  bypass_take;
   logic                  do_push;
   logic                  do_pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Fall-through only shows the incoming word while nothing is stored.
   assign bypass_show = FALL_THROUGH && empty && elem_in_valid_i;

   assign elem_in_ready_o  = !full && !flush_i;
   assign elem_out_valid_o = !flush_i && (!empty || bypass_show);
   assign elem_out_o       = bypass_show ? elem_in_i : mem[rd_ptr];

   assign push_req    = elem_in_valid_i && elem_in_ready_o;
   assign pop_req     = elem_out_valid_o && elem_out_ready_i;
   assign bypass_take = bypass_show && push_req && pop_req;
   assign do_push     = push_req && !bypass_take;
   assign do_pop      = pop_req && !bypass_take;

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + CW'(1);
      else if (do_pop && !do_push)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (flush_i) begin
         // Storage is intentionally kept; only the bookkeeping is cleared.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= elem_in_i;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         count <= count_nxt;
      end
   end

`ifdef SYNC_FIFO_WATERMARK_EN
   logic [CW-1:0] max_count;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i)
         max_count <= '0;
      else if (flush_i)
         max_count <= '0;
      else if (count_nxt > max_count)
         max_count <= count_nxt;
   end

   assign max_count_o = max_count;
`endif

   assign count_o        = count;
   assign almost_full_o  = (count >= CW'(AF_LEVEL));
   assign almost_empty_o = (count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-output instance and a fall-through instance, both DEPTH=5.
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       arst;
   logic       flush;
   logic [7:0] din;
   logic       vin;
   logic       rin;
   logic [7:0] dout;
   logic       vout;
   logic       rout;
   logic [2:0] cnt;
   logic       af;
   logic       ae;

   logic       b_flush;
   logic [7:0] b_din;
   logic       b_vin;
   logic       b_rin;
   logic [7:0] b_dout;
   logic       b_vout;
   logic       b_rout;
   logic [2:0] b_cnt;
   logic       b_af;
   logic       b_ae;

`ifdef SYNC_FIFO_WATERMARK_EN
   logic [2:0] max_cnt;
   logic [2:0] b_max_cnt;
`endif

   int passed = 0;
   int total  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_head;

   always #5 clk = ~clk;

   sync_fifo #(.ELEM_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b0)) dut (
      .clk_i            (clk),
      .arst_i           (arst),
      .flush_i          (flush),
      .elem_in_i        (din),
      .elem_in_valid_i  (vin),
      .elem_in_ready_o  (rin),
      .elem_out_o       (dout),
      .elem_out_valid_o (vout),
      .elem_out_ready_i (rout),
`ifdef SYNC_FIFO_WATERMARK_EN
      .max_count_o      (max_cnt),
`endif
      .count_o          (cnt),
      .almost_full_o    (af),
      .almost_empty_o   (ae)
   );

   sync_fifo #(.ELEM_WIDTH(8), .DEPTH(5), .FALL_THROUGH(1'b1)) dut_ft (
      .clk_i            (clk),
      .arst_i           (arst),
      .flush_i          (b_flush),
      .elem_in_i        (b_din),
      .elem_in_valid_i  (b_vin),
      .elem_in_ready_o  (b_rin),
      .elem_out_o       (b_dout),
      .elem_out_valid_o (b_vout),
      .elem_out_ready_i (b_rout),
`ifdef SYNC_FIFO_WATERMARK_EN
      .max_count_o      (b_max_cnt),
`endif
      .count_o          (b_cnt),
      .almost_full_o    (b_af),
      .almost_empty_o   (b_ae)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(rin), 32'd1);
      chk({tag, "_valid"}, 32'(vout), 32'd0);
      chk({tag, "_dout"}, 32'(dout), 32'h00);
      chk({tag, "_count"}, 32'(cnt), 32'd0);
      chk({tag, "_af"}, 32'(af), 32'd0);
      chk({tag, "_ae"}, 32'(ae), 32'd1);
`ifdef SYNC_FIFO_WATERMARK_EN
      chk({tag, "_max"}, 32'(max_cnt), 32'd0);
`endif
   endtask

   initial begin
      arst = 1'b1;
      flush = 1'b0; din = 8'h00; vin = 1'b0; rout = 1'b0;
      b_flush = 1'b0; b_din = 8'h00; b_vin = 1'b0; b_rout = 1'b0;
      #3;
      chk_reset_outputs("reset");
      chk("ft_reset_valid", 32'(b_vout), 32'd0);
      chk("ft_reset_dout", 32'(b_dout), 32'h00);
      #4;
      arst = 1'b0;
      cyc();

      // Fill to DEPTH; almost_full from count 4.
      for (int i = 0; i < 5; i++) begin
         din = 8'h11 + 8'(i);
         vin = 1'b1;
         #1;
         chk("fill_ready", 32'(rin), 32'd1);
         cyc();
         chk("fill_count", 32'(cnt), 32'(i + 1));
         chk("fill_af", 32'(af), (i + 1 >= 4) ? 32'd1 : 32'd0);
         chk("fill_ae", 32'(ae), (i + 1 <= 1) ? 32'd1 : 32'd0);
         chk("fill_head", 32'(dout), 32'h11);
      end
      din = 8'h16;
      #1;
      chk("full_ready", 32'(rin), 32'd0);
      chk("full_valid", 32'(vout), 32'd1);
`ifdef SYNC_FIFO_WATERMARK_EN
      chk("full_max", 32'(max_cnt), 32'd5);
`endif
      cyc();
      chk("overfill_count", 32'(cnt), 32'd5);
      chk("overfill_head", 32'(dout), 32'h11);
      vin = 1'b0;

      // Drain in order.
      rout = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("drain_valid", 32'(vout), 32'd1);
         chk("drain_data", 32'(dout), 32'h11 + 32'(i));
         cyc();
         chk("drain_count", 32'(cnt), 32'(4 - i));
      end
      rout = 1'b0;
      chk("empty_valid", 32'(vout), 32'd0);
      chk("empty_ae", 32'(ae), 32'd1);

      // Refill 3 after wrap: write pointer continues from 0.
      for (int i = 0; i < 3; i++) begin
         din = 8'h21 + 8'(i);
         vin = 1'b1;
         exp_q.push_back(din);
         cyc();
      end
      vin = 1'b0;
      chk("refill_count", 32'(cnt), 32'd3);
      chk("refill_head", 32'(dout), 32'h21);
      chk("refill_no_x", 32'(^dout === 1'bx), 32'd0);

      rout = 1'b1;
      #1;
      exp_head = exp_q.pop_front();
      chk("pop_to_two", 32'(dout), 32'(exp_head));
      cyc();
      rout = 1'b0;
      chk("two_count", 32'(cnt), 32'd2);

      // Steady push+pop at count 2.
      for (int i = 0; i < 10; i++) begin
         din = 8'h30 + 8'(i);
         vin = 1'b1;
         rout = 1'b1;
         #1;
         exp_head = exp_q.pop_front();
         chk("stream_data", 32'(dout), 32'(exp_head));
         exp_q.push_back(din);
         cyc();
         chk("stream_count", 32'(cnt), 32'd2);
         chk("stream_ae", 32'(ae), 32'd0);
      end
      rout = 1'b0;
      din = 8'h3A;
      cyc();
      vin = 1'b0;
      chk("preflush_count", 32'(cnt), 32'd3);
      chk("preflush_head", 32'(dout), 32'h38);

      // Flush concurrent with push and pop.
      flush = 1'b1;
      vin = 1'b1;
      din = 8'h77;
      rout = 1'b1;
      #1;
      chk("flush_ready", 32'(rin), 32'd0);
      chk("flush_valid", 32'(vout), 32'd0);
      cyc();
      flush = 1'b0;
      vin = 1'b0;
      rout = 1'b0;
      #1;
      chk("postflush_count", 32'(cnt), 32'd0);
      chk("postflush_valid", 32'(vout), 32'd0);
      chk("postflush_ready", 32'(rin), 32'd1);
      chk("postflush_ae", 32'(ae), 32'd1);
`ifdef SYNC_FIFO_WATERMARK_EN
      chk("postflush_max", 32'(max_cnt), 32'd0);
`endif
      cyc();

      // Build count 4, then async reset mid-transfer.
      for (int i = 0; i < 4; i++) begin
         din = 8'h41 + 8'(i);
         vin = 1'b1;
         cyc();
      end
      chk("prereset_count", 32'(cnt), 32'd4);
      chk("prereset_af", 32'(af), 32'd1);
      din = 8'h45;
      rout = 1'b1;
      #1;
      arst = 1'b1;
      vin = 1'b0;
      rout = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      #1;
      arst = 1'b0;
      cyc();
      din = 8'h5A;
      vin = 1'b1;
      cyc();
      vin = 1'b0;
      chk("postreset_count", 32'(cnt), 32'd1);
      chk("postreset_head", 32'(dout), 32'h5A);
      chk("postreset_valid", 32'(vout), 32'd1);

      // Fall-through instance.
      b_din = 8'hA5;
      b_vin = 1'b1;
      b_rout = 1'b1;
      #1;
      chk("ft_bypass_valid", 32'(b_vout), 32'd1);
      chk("ft_bypass_data", 32'(b_dout), 32'hA5);
      cyc();
      chk("ft_bypass_count", 32'(b_cnt), 32'd0);
      b_rout = 1'b0;
      #1;
      chk("ft_stall_valid", 32'(b_vout), 32'd1);
      cyc();
      b_vin = 1'b0;
      b_din = 8'h00;
      #1;
      chk("ft_stored_count", 32'(b_cnt), 32'd1);
      chk("ft_stored_data", 32'(b_dout), 32'hA5);
      chk("ft_stored_valid", 32'(b_vout), 32'd1);
      b_rout = 1'b1;
      cyc();
      b_rout = 1'b0;
      chk("ft_drained_count", 32'(b_cnt), 32'd0);
      chk("ft_drained_valid", 32'(b_vout), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
